// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 neighbourhood window datapath.
package median_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } state_t;

    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int CENTRE = 4;
    localparam int ROW_W  = 16;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one write port, one synchronous read port.
// A read and write to the same address on one edge returns the old contents.
module line_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 column shift
// register, emitting interior windows two cycles after the bottom-right pixel.
module window_3x3
    import median_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  in_eol,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    output logic [9*DATA_W-1:0]   out_window
);

    localparam int AW = $clog2(MAX_W);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COL_LIM = CW'(MAX_W);

    state_t            state, state_nxt;
    logic [CW-1:0]     col;
    logic [ROW_W-1:0]  row;
    logic              ok, emit;
    logic [AW-1:0]     addr;

    logic              v1, e1, e2, fwd_hit;
    logic [AW-1:0]     addr1;
    logic [DATA_W-1:0] d1, fwd_data, a_rdata, b_rdata, b_col;
    logic [DATA_W-1:0] win [ROWS][COLS];

    // Pixel position counters; col saturates at MAX_W so overlong rows stay ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (in_sof) begin
                col <= in_eol ? '0 : CW'(1);
                row <= in_eol ? ROW_W'(1) : '0;
            end else if (in_eol) begin
                col <= '0;
                if (row != '1) begin
                    row <= row + ROW_W'(1);
                end
            end else if (col < COL_LIM) begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start-of-frame pixel is always position (0,0), even mid-row.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        ok        = in_valid && (in_sof || (col < COL_LIM));
        addr      = in_sof ? '0 : col[AW-1:0];
        case (state)
            ST_IDLE: begin
                if (in_valid && in_sof) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (in_valid && in_sof)    state_nxt = ST_FILL;
                else if (row >= ROW_W'(2)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (in_valid && in_sof) state_nxt = ST_FILL;
                else                    emit = ok && (col >= CW'(2));
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_W)) u_ram_a (
        .clk   (clk),
        .we    (ok),
        .waddr (addr),
        .wdata (in_data),
        .re    (ok),
        .raddr (addr),
        .rdata (a_rdata)
    );

    line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_W)) u_ram_b (
        .clk   (clk),
        .we    (v1),
        .waddr (addr1),
        .wdata (a_rdata),
        .re    (ok),
        .raddr (addr),
        .rdata (b_rdata)
    );

    // Buffer B is written a cycle late; forward that write if the next pixel reads it.
    assign b_col = fwd_hit ? fwd_data : b_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            e1       <= 1'b0;
            addr1    <= '0;
            d1       <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            v1 <= ok;
            e1 <= emit;
            if (ok) begin
                addr1    <= addr;
                d1       <= in_data;
                fwd_hit  <= v1 && (addr1 == addr);
                fwd_data <= a_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e2 <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            e2 <= v1 && e1;
            if (v1) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                win[0][COLS-1] <= b_col;
                win[1][COLS-1] <= a_rdata;
                win[2][COLS-1] <= d1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_window <= '0;
        end else begin
            out_valid <= e2;
            if (e2) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        out_window[DATA_W*(COLS*r+c) +: DATA_W] <= win[r][c];
                    end
                end
            end
        end
    end

endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter MAX_W, default 1024, maximum line length in pixels (power of two).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  pixel qualifier; no backpressure.
REQ-006 SHALL have port in_sof  input  1  start of frame, qualified by in_valid, marks pixel (0,0).
REQ-007 SHALL have port in_eol  input  1  end of line, qualified by in_valid, marks the last pixel of a row.
REQ-008 SHALL have port in_data  input  DATA_W  pixel value.
REQ-009 SHALL have port out_valid  output  1  window qualifier, one-cycle pulse per window.
REQ-010 SHALL have port out_window  output  9*DATA_W  3x3 window; element (r,c) at bits [DATA_W*(3r+c) +: DATA_W]; r=0 oldest row, c=0 oldest column; centre = element 4.

Function
REQ-011 SHALL track column counter col and row counter row, advanced only on accepted pixels (in_valid=1).
REQ-012 SHALL reset col and row to 0 on an accepted in_sof pixel, which itself becomes pixel (0,0).
REQ-013 SHALL, on an accepted in_eol pixel, set col to 0 and increment row (saturating at all-ones).
REQ-014 SHALL hold two circular line buffers, depth MAX_W, addressed by col: read-before-write, buffer A receives in_data, buffer B receives buffer A's old contents.
REQ-015 SHALL ignore pixels with col >= MAX_W (no write, no window) until the next in_eol or in_sof.
REQ-016 SHALL run FSM IDLE -> FILL -> RUN: IDLE until first in_sof; FILL while row < 2; RUN once row >= 2; any in_sof returns to FILL.
REQ-017 SHALL shift three 3-deep column registers (rows r-2, r-1, r) on each accepted pixel; they SHALL hold when in_valid=0.
REQ-018 SHALL assert out_valid exactly 2 cycles after an accepted pixel at (row>=2, col>=2) in RUN; window centred on (row-1, col-1).
REQ-019 SHALL produce no windows for border pixels (first two rows, first two columns); output is the interior only.
REQ-020 SHALL hold out_window stable when out_valid=0.
REQ-021 SHALL accept in_valid on consecutive cycles and with arbitrary gaps; latency is 2 cycles regardless of gaps.
REQ-022 SHALL give in_sof priority over in_eol when both are set on one pixel (treat as one-pixel row 0, next pixel is (1,0)).
REQ-023 SHALL handle line lengths that vary between rows: buffer contents beyond a shorter previous line are stale and are used unchanged.

Reset
REQ-024 SHALL on rst=1 immediately clear out_valid=0, out_window=0, col=0, row=0, FSM=IDLE, pipeline valid flags=0.
REQ-025 SHALL not clear line buffer memory on reset; contents are don't-care until rewritten.
REQ-026 SHALL, after reset mid-frame, emit nothing until the next in_sof.

Structure
REQ-027 SHALL place the FSM state type and window index constants (ROWS=3, COLS=3, CENTRE=4) in shared package median_pkg.
REQ-028 SHALL instantiate line buffers as sub-module line_ram (simple dual-port, synchronous read, one write port), twice.

Verification
REQ-029 SHALL test 4x4 frame of values 1..16, continuous in_valid, MAX_W=8 -> 4 windows; first = {1,2,3,5,6,7,9,10,11} two cycles after pixel 11; last centre = 11.
REQ-030 SHALL test the same frame with in_valid toggling 1,0,1,0 -> identical 4 windows, out_window stable between pulses.
REQ-031 SHALL test 6-pixel rows with MAX_W=4 -> pixels at col 4,5 ignored; only cols 2,3 produce windows per row >= 2.
REQ-032 SHALL test rst asserted after pixel 10 of a 4x4 frame -> out_valid stays 0; restart with in_sof produces 4 correct windows.
REQ-033 SHALL test in_sof arriving at row 3 col 1 -> counters return to (0,0); no window until new row 2, col 2.
REQ-034 SHALL test back-to-back 3x3 frames (values 1..9, then 11..19) -> windows {1..9} and {11..19}, each centre 5 and 15.
